// File: rtl/fpu_pkg.sv
// Shared single-precision field definitions and helpers for the FPU units.
package fpu_pkg;

  localparam int EXP_W       = 8;
  localparam int MAN_W       = 23;
  localparam int BIAS        = 127;
  localparam int EXP_MAX     = 255;
  localparam int SIG_EXT_W   = 27;
  // Alignment shifts at or beyond this leave only the sticky bit of the smaller operand.
  localparam int SHIFT_LIMIT = SIG_EXT_W - 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  function automatic fp_t fp_unpack(input logic [31:0] word);
    return fp_t'(word);
  endfunction

  function automatic logic [31:0] fp_pack(input logic sign,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/lzc27.sv
// Leading-zero counter for 27-bit extended significands; count is 27 for an all-zero input.
module lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    count    = 5'd27;
    all_zero = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) begin
        count    = 5'(26 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Three-stage pipelined single-precision subtractor y = x1 - x2 with valid/ready handshakes.
// Optional build macro FSUB_ROUND_NEAREST_EN: round-to-nearest-even in the normalize stage;
// without it results are truncated.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  logic advance;

  // Align stage signals
  fp_t         a_op, b_op, big_op, small_op;
  logic [30:0] a_key, b_key;
  logic [23:0] big_sig24, small_sig24;
  logic [7:0]  exp_diff;
  logic [26:0] big_ext, small_full, small_shifted, shifted_lost, small_ext;

  // Stage registers
  logic             s1_valid, s2_valid;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             s1_sign, s2_sign;
  logic [7:0]       s1_exp, s2_exp;
  logic [26:0]      s1_big, s1_small;
  logic             s1_eff_sub;
  logic [27:0]      s2_sum;

  // Add/sub and normalize stage signals
  logic [27:0] sum_next;
  logic [4:0]  lz_count;
  logic        lz_zero;
  logic [26:0] norm;
  logic [9:0]  exp_n;
  logic [22:0] man_n;
  logic [31:0] y_next;

  // A global stall: everything moves only when the output slot is free or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;

  // Align: negate x2, order by magnitude, shift the smaller significand with sticky collection.
  always_comb begin
    a_op      = fp_unpack(x1);
    b_op      = fp_unpack(x2);
    b_op.sign = ~b_op.sign;
    a_key     = {a_op.exp, (a_op.exp == 8'd0) ? 23'd0 : a_op.man};
    b_key     = {b_op.exp, (b_op.exp == 8'd0) ? 23'd0 : b_op.man};
    if (a_key >= b_key) begin
      big_op   = a_op;
      small_op = b_op;
    end else begin
      big_op   = b_op;
      small_op = a_op;
    end
    big_sig24   = (big_op.exp == 8'd0)   ? 24'd0 : {1'b1, big_op.man};
    small_sig24 = (small_op.exp == 8'd0) ? 24'd0 : {1'b1, small_op.man};
    exp_diff    = big_op.exp - small_op.exp;
    big_ext     = {big_sig24, 3'b000};
    small_full  = {small_sig24, 3'b000};
    {small_shifted, shifted_lost} = {small_full, 27'd0} >> exp_diff;
    if (exp_diff >= 8'(SHIFT_LIMIT)) begin
      small_ext = {26'd0, |small_sig24};
    end else begin
      small_ext = {small_shifted[26:1], small_shifted[0] | (|shifted_lost)};
    end
  end

  // Add/sub: the larger magnitude comes first, so the subtraction never goes negative.
  always_comb begin
    if (s1_eff_sub) begin
      sum_next = {1'b0, s1_big} - {1'b0, s1_small};
    end else begin
      sum_next = {1'b0, s1_big} + {1'b0, s1_small};
    end
  end

  lzc27 u_lzc (
    .value    (s2_sum[26:0]),
    .count    (lz_count),
    .all_zero (lz_zero)
  );

`ifdef FSUB_ROUND_NEAREST_EN
  logic        round_up;
  logic [24:0] rounded;
`else
  logic [3:0]  unused_trunc_bits;
  assign unused_trunc_bits = {norm[26], norm[2:0]};
`endif

  // Normalize: fold a carry back in or shift out leading zeros, then round/truncate and pack.
  always_comb begin
    norm   = '0;
    exp_n  = '0;
    man_n  = '0;
    y_next = '0;
    if (s2_sum[27]) begin
      norm  = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      exp_n = {2'b00, s2_exp} + 10'd1;
    end else begin
      norm  = s2_sum[26:0] << lz_count;
      exp_n = {2'b00, s2_exp} - {5'd0, lz_count};
    end
`ifdef FSUB_ROUND_NEAREST_EN
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rounded[24]) begin
      man_n = rounded[23:1];
      exp_n = exp_n + 10'd1;
    end else begin
      man_n = rounded[22:0];
    end
`else
    man_n = norm[25:3];
`endif
    if (lz_zero && !s2_sum[27]) begin
      y_next = 32'd0;
    end else if (exp_n[9] || exp_n == 10'd0) begin
      y_next = {s2_sign, 31'd0};
    end else if (exp_n >= 10'(EXP_MAX)) begin
      y_next = fp_pack(s2_sign, 8'(EXP_MAX), 23'd0);
    end else begin
      y_next = fp_pack(s2_sign, exp_n[7:0], man_n);
    end
  end

  // Valid bits and the output register; flush beats a stall, reset beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= 32'd0;
      out_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (advance) begin
        s1_valid  <= in_valid && in_ready;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
      end
      if (advance && s2_valid) begin
        y       <= y_next;
        out_tag <= s2_tag;
      end
    end
  end

  // Datapath stage registers; contents are don't-care whenever the matching valid bit is low.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_tag     <= in_tag;
      s1_sign    <= big_op.sign;
      s1_exp     <= big_op.exp;
      s1_big     <= big_ext;
      s1_small   <= small_ext;
      s1_eff_sub <= a_op.sign ^ b_op.sign;
      s2_tag     <= s1_tag;
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_sum     <= sum_next;
    end
  end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined single-precision subtractor: y = x1 - x2.
- Companion to the team's combinational FP adder; covers the opposite operation for the FPU's FSUB opcode.
- Three-stage pipeline with valid/ready handshakes on both sides, so the FPU issue logic can stall and flush it.
- Sits between the FPU operand-read stage and the writeback arbiter.

Parameters:
- TAG_W, 5, width of the opaque tag (destination register id) carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of every in-flight operation.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pipeline accepts this cycle.
- x1  in  32  IEEE-754 single minuend.
- x2  in  32  IEEE-754 single subtrahend.
- in_tag  in  TAG_W  tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- y  out  32  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Stages:
  - S1 (align): invert sign of x2, compare magnitudes, swap so the larger operand is first, compute exponent difference, right-shift the smaller significand (hidden 1 plus 2 guard bits plus sticky; shifts of 26 or more give sticky only).
  - S2 (add/sub): effective add or subtract on a 27-bit significand; result sign taken from the larger operand.
  - S3 (normalize): leading-zero count, left shift or 1-bit right shift, exponent adjust, pack.
- Latency: 3 cycles from an in_valid&&in_ready cycle to out_valid, with no stall.
- Throughput: 1 operation per cycle.
- Stall (global): advance = !out_valid || out_ready. in_ready = advance. When advance=0, every stage register holds its value. Bubbles are not compressed.
- out_valid/y/out_tag stay stable while out_valid && !out_ready.
- Reset: all stage valid bits 0, out_valid=0, y=0, out_tag=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight operations are discarded with no output.
- flush: clears all stage valid bits on the next edge. Input presented in the same cycle is not accepted (in_ready is forced to 0 while flush=1). Data registers may keep stale values.
- flush and a stall in the same cycle: flush wins.
- Arithmetic:
  - Exponent 0 input is treated as zero (denormals flushed).
  - Exponent 255 is not special-cased (no NaN/Inf semantics).
  - Exact-zero result is +0 (0x00000000).
  - Result exponent <= 0 flushes to a signed zero.
  - Result exponent >= 255 saturates to signed infinity (e=255, m=0).
  - Rounding without the macro: truncation (guard/sticky discarded).
- Equal operands (x1==x2) give +0.

Optional Feature:
- Macro: FSUB_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using guard, round and sticky bits in S3. A rounding carry renormalizes and bumps the exponent, which can saturate to infinity. Latency is unchanged.
- Undefined: truncation only; the rounding adder is not instantiated.

Decomposition:
- Package fpu_pkg holds:
  - constants: EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255, SIG_EXT_W=27;
  - a struct typedef for {sign, exp, man};
  - functions for field unpack and pack.
- One sub-module, lzc27: combinational leading-zero counter, 27-bit input, 5-bit count plus all-zero flag. It is used in S3 and is reusable by the other FPU units.

Test Plan:
- Basic: 0x40400000 - 0x3F800000 (3.0-1.0) -> y=0x40000000 exactly 3 cycles later. 0x3FC00000 - 0x3FA00000 -> 0x3E800000.
- Sign and cancellation: 0x3F800000 - 0x3F800000 -> 0x00000000. 0x3F800000 - 0xBF800000 -> 0x40000000. 0xBF800000 - 0x3F800000 -> 0xC0000000.
- Saturation and flush: 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000. 0x00400000 - 0x00000000 (denormal) -> 0x00000000.
- Rounding: 0x3F800000 - 0x33000000 -> 0x3F7FFFFF without the macro, 0x3F800000 with FSUB_ROUND_NEAREST_EN.
- Handshake:
  - Stream 8 back-to-back operations and hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 during the hold; output stable; all 8 results in order with correct tags; no loss or duplication.
- Flush/reset:
  - Assert flush with 3 operations in flight: no out_valid for them; the next operation issued returns correctly after 3 cycles.
  - Assert rst mid-stream: out_valid=0 and y=0 on the next cycle.
